// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between UartRx and the host, with a FWFT read side.
// Ports: clock_i/reset_i (sync, active-high); rx_data_i/rx_ready_i/rx_ack_o to UartRx;
//        read_i/data_o/empty_o/full_o/count_o to the host; overflow_o/overflow_clear_i.
// Optional macro UART_RX_FIFO_DROP_ON_FULL_EN: drop and flag bytes that arrive while full.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_ready_i,
    output logic                  rx_ack_o,
    input  logic                  read_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    input  logic                  overflow_clear_i
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  wr_en;
    logic                  rd_en;
    logic                  take;
`ifdef UART_RX_FIFO_DROP_ON_FULL_EN
    logic                  drop;
    logic                  overflow_q;
`else
    logic                  unused_overflow_clear;
`endif

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign data_o  = mem[rd_ptr_q];
    assign rd_en   = read_i && !empty_o && !reset_i;

    // A pending byte is taken (acked) when there is room, or always when
    // dropping on full is enabled.
`ifdef UART_RX_FIFO_DROP_ON_FULL_EN
    assign take = rx_ready_i;
`else
    assign take = rx_ready_i && !full_o;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (take) state_d = ACK;
            ACK:      state_d = WAIT_LOW;
            WAIT_LOW: if (!rx_ready_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_ack_o = (state_q == ACK);
        wr_en    = (state_q == IDLE) && rx_ready_i && !full_o && !reset_i;
    end

    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= rx_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef UART_RX_FIFO_DROP_ON_FULL_EN
    assign drop = (state_q == IDLE) && rx_ready_i && full_o;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (overflow_clear_i) begin
            overflow_q <= 1'b0;
        end
    end

    assign overflow_o = overflow_q;
`else
    assign overflow_o = 1'b0;
    assign unused_overflow_clear = overflow_clear_i;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo.
// A queue model tracks contents; a negedge process compares every cycle.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] rx_data_i = '0;
    logic       rx_ready_i = 1'b0;
    logic       rx_ack_o;
    logic       read_i = 1'b0;
    logic [7:0] data_o;
    logic       empty_o;
    logic       full_o;
    logic [4:0] count_o;
    logic       overflow_o;
    logic       overflow_clear_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int acks = 0;
    int snap;

    uart_rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clock_i(clk), .reset_i(reset_i),
        .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i), .rx_ack_o(rx_ack_o),
        .read_i(read_i), .data_o(data_o), .empty_o(empty_o), .full_o(full_o),
        .count_o(count_o), .overflow_o(overflow_o),
        .overflow_clear_i(overflow_clear_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of accepted bytes. A byte is taken when ready is seen
    // while no handshake is in progress; the ack appears the following cycle,
    // and after it the sender must drop ready before another byte is taken.
    logic [7:0] q[$];
    bit started = 0;
    bit m_ack = 0;
    bit m_busy = 0;
    bit m_ovf = 0;

    always @(posedge clk) begin
        bit was_full, accept;
        if (reset_i) begin
            q.delete();
            m_ack = 0;
            m_busy = 0;
            m_ovf = 0;
            started = 1;
        end else if (started) begin
            was_full = (q.size() == 16);
`ifdef UART_RX_FIFO_DROP_ON_FULL_EN
            accept = rx_ready_i && !m_ack && !m_busy;
`else
            accept = rx_ready_i && !m_ack && !m_busy && !was_full;
`endif
            m_busy = m_busy ? rx_ready_i : m_ack;
            m_ack = accept;
            if (read_i && q.size() != 0) void'(q.pop_front());
            if (accept && !was_full) q.push_back(rx_data_i);
`ifdef UART_RX_FIFO_DROP_ON_FULL_EN
            if (accept && was_full) m_ovf = 1;
            else if (overflow_clear_i) m_ovf = 0;
`endif
        end
    end

    always @(negedge clk) begin
        if (rx_ack_o === 1'b1) acks++;
        if (started) begin
            chk("m_count", count_o, q.size());
            chk("m_empty", empty_o, q.size() == 0);
            chk("m_full", full_o, q.size() == 16);
            chk("m_ack", rx_ack_o, m_ack);
            chk("m_ovf", overflow_o, m_ovf);
            if (q.size() != 0) chk("m_data", data_o, q[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string name);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rx_ack_o) begin
                seen = 1;
                break;
            end
        end
        chk({name, "_ack_seen"}, seen, 1);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data_i = b;
        rx_ready_i = 1'b1;
        wait_ack("send");
        rx_ready_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic pop();
        read_i = 1'b1;
        tick();
        read_i = 1'b0;
    endtask

    initial begin
        logic [7:0] last;
        tick();
        tick();
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_ack", rx_ack_o, 0);
        chk("rst_ovf", overflow_o, 0);
        reset_i = 1'b0;
        tick();

        // 1: single byte
        snap = acks;
        send(8'h55);
        chk("t1_acks", acks - snap, 1);
        chk("t1_count", count_o, 1);
        chk("t1_empty", empty_o, 0);
        chk("t1_data", data_o, 8'h55);
        pop();

        // 2: ready held after ack
        snap = acks;
        rx_data_i = 8'h66;
        rx_ready_i = 1'b1;
        wait_ack("t2");
        repeat (6) tick();
        chk("t2_acks", acks - snap, 1);
        chk("t2_count", count_o, 1);
        rx_ready_i = 1'b0;
        tick();
        tick();
        pop();
        chk("t2_empty", empty_o, 1);
        chk("t2_count0", count_o, 0);

        // 3: fill and drain
        for (int i = 0; i < 16; i++) send(8'(i));
        chk("t3_full", full_o, 1);
        chk("t3_count", count_o, 16);
        for (int i = 0; i < 16; i++) begin
            chk("t3_seq", data_o, 8'(i));
            pop();
        end
        pop();
        chk("t3_rd_empty", count_o, 0);

        // 4: byte pending while full
        for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
        snap = acks;
        rx_data_i = 8'hAA;
        rx_ready_i = 1'b1;
`ifdef UART_RX_FIFO_DROP_ON_FULL_EN
        wait_ack("t4");
        rx_ready_i = 1'b0;
        tick();
        tick();
        chk("t4_acks", acks - snap, 1);
        chk("t4_count", count_o, 16);
        chk("t4_ovf", overflow_o, 1);
        overflow_clear_i = 1'b1;
        tick();
        overflow_clear_i = 1'b0;
        chk("t4_ovf_clr", overflow_o, 0);
        last = 8'h00;
        for (int i = 0; i < 16; i++) begin
            last = data_o;
            pop();
        end
        chk("t4_last", last, 8'h1F);
`else
        repeat (5) tick();
        chk("t4_noack", acks - snap, 0);
        pop();
        wait_ack("t4");
        rx_ready_i = 1'b0;
        tick();
        tick();
        chk("t4_count", count_o, 16);
        last = 8'h00;
        for (int i = 0; i < 16; i++) begin
            last = data_o;
            pop();
        end
        chk("t4_last", last, 8'hAA);
`endif

        // 5: simultaneous capture and read across pointer wrap
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
        for (int i = 5; i < 20; i++) begin
            rx_data_i = 8'h30 + 8'(i);
            rx_ready_i = 1'b1;
            read_i = 1'b1;
            tick();
            read_i = 1'b0;
            chk("t5_ack", rx_ack_o, 1);
            chk("t5_count", count_o, 5);
            rx_ready_i = 1'b0;
            tick();
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            chk("t5_order", data_o, 8'h3F + 8'(j));
            pop();
        end

        // 6: reset during ACK
        for (int i = 0; i < 3; i++) send(8'h70 + 8'(i));
        rx_data_i = 8'h99;
        rx_ready_i = 1'b1;
        tick();
        chk("t6_in_ack", rx_ack_o, 1);
        chk("t6_count3", count_o, 4);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("t6_count", count_o, 0);
        chk("t6_empty", empty_o, 1);
        chk("t6_ack", rx_ack_o, 0);
        chk("t6_ovf", overflow_o, 0);
        tick();
        chk("t6_recapture", count_o, 1);
        chk("t6_data", data_o, 8'h99);
        rx_ready_i = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
